// File: rtl/i2c_txn_ctrl.sv
// rtl/i2c_txn_ctrl.sv - I2C master for single-byte register write / register read transactions
// Bit timing is four phases of CLK_DIV clocks; scl/sda decode from state, phase and bit index.
module i2c_txn_ctrl #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] address,
   input  logic [7:0] register,
   input  logic [7:0] data_wr,
   input  logic       sda_in,
   output logic       scl,
   output logic       sda,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic [7:0] data_rd
);

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ACK_A, REG, ACK_R, WDATA, ACK_W,
      RSTART, RADDR, ACK_RA, RDATA, MNACK, STOP
   } t_state;

   t_state      r_state;
   t_state      w_next;
   logic [7:0]  r_presc;
   logic [1:0]  r_phase;
   logic [2:0]  r_bit;
   logic        r_rw;
   logic [6:0]  r_addr;
   logic [7:0]  r_reg;
   logic [7:0]  r_wdata;
   logic [7:0]  r_shift;
   logic        r_smp;
   logic        r_busy;
   logic        r_done;
   logic        r_ack_err;
   logic [7:0]  r_data_rd;

   logic        w_accept;
   logic        w_ph_end;
   logic        w_bit_end;
   logic        w_sample;
   logic        w_sda_bit;
   logic        w_last_bit;
   logic        w_byte_state;
   logic        w_ack_state;
   logic [7:0]  w_tx_byte;
   logic        w_scl;
   logic        w_sda;

   assign w_accept     = (r_state == IDLE) && !r_busy && start;
   assign w_ph_end     = (r_presc == 8'(CLK_DIV - 1));
   assign w_bit_end    = w_ph_end && (r_phase == 2'd3);
   assign w_sample     = (r_phase == 2'd3) && (r_presc == 8'd0);
   // With CLK_DIV=1 the sample and the bit end share a cycle, so use sda_in directly then.
   assign w_sda_bit    = w_sample ? sda_in : r_smp;
   assign w_last_bit   = (r_bit == 3'd7);
   assign w_byte_state = (r_state == ADDR) || (r_state == REG) || (r_state == WDATA) ||
                         (r_state == RADDR) || (r_state == RDATA);
   assign w_ack_state  = (r_state == ACK_A) || (r_state == ACK_R) ||
                         (r_state == ACK_W) || (r_state == ACK_RA);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (r_state == IDLE) begin
         if (w_accept) w_next = START;
      end else if (w_bit_end) begin
         case (r_state)
            START:   w_next = ADDR;
            ADDR:    if (w_last_bit) w_next = ACK_A;
            ACK_A:   w_next = w_sda_bit ? STOP : REG;
            REG:     if (w_last_bit) w_next = ACK_R;
            ACK_R:   w_next = w_sda_bit ? STOP : (r_rw ? RSTART : WDATA);
            WDATA:   if (w_last_bit) w_next = ACK_W;
            ACK_W:   w_next = STOP;
            RSTART:  w_next = RADDR;
            RADDR:   if (w_last_bit) w_next = ACK_RA;
            ACK_RA:  w_next = w_sda_bit ? STOP : RDATA;
            RDATA:   if (w_last_bit) w_next = MNACK;
            MNACK:   w_next = STOP;
            default: w_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || (r_state == IDLE)) begin
         r_presc <= 8'd0;
         r_phase <= 2'd0;
         r_bit   <= 3'd0;
      end else if (w_ph_end) begin
         r_presc <= 8'd0;
         r_phase <= r_phase + 2'd1;
         if (r_phase == 2'd3) r_bit <= w_byte_state ? r_bit + 3'd1 : 3'd0;
      end else begin
         r_presc <= r_presc + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ack_err <= 1'b0;
         r_data_rd <= 8'h00;
         r_shift   <= 8'h00;
         r_smp     <= 1'b1;
         r_rw      <= 1'b0;
         r_addr    <= 7'h00;
         r_reg     <= 8'h00;
         r_wdata   <= 8'h00;
      end else begin
         r_done <= (r_state == STOP) && w_bit_end;
         if (w_accept) begin
            r_busy    <= 1'b1;
            r_ack_err <= 1'b0;
            r_rw      <= rw;
            r_addr    <= address;
            r_reg     <= register;
            r_wdata   <= data_wr;
         end else if (r_done) begin
            r_busy <= 1'b0;
         end
         if (w_sample) begin
            r_smp <= sda_in;
            if (w_ack_state && sda_in) r_ack_err <= 1'b1;
            if (r_state == RDATA) begin
               r_shift <= {r_shift[6:0], sda_in};
               if (w_last_bit) r_data_rd <= {r_shift[6:0], sda_in};
            end
         end
      end
   end

   always_comb begin
      case (r_state)
         ADDR:    w_tx_byte = {r_addr, 1'b0};
         RADDR:   w_tx_byte = {r_addr, 1'b1};
         WDATA:   w_tx_byte = r_wdata;
         default: w_tx_byte = r_reg;
      endcase
   end

   // Start-type edges land on the P1/P2 boundary with SCL high; data changes only in P0.
   always_comb begin
      w_scl = 1'b1;
      w_sda = 1'b1;
      case (r_state)
         IDLE: begin
            w_scl = 1'b1;
            w_sda = 1'b1;
         end
         START: begin
            w_scl = (r_phase != 2'd3);
            w_sda = !r_phase[1];
         end
         RSTART: begin
            w_scl = (r_phase == 2'd1) || (r_phase == 2'd2);
            w_sda = !r_phase[1];
         end
         STOP: begin
            w_scl = r_phase[1];
            w_sda = (r_phase == 2'd3);
         end
         ADDR, REG, WDATA, RADDR: begin
            w_scl = r_phase[1];
            w_sda = w_tx_byte[3'd7 - r_bit];
         end
         default: begin
            w_scl = r_phase[1];
            w_sda = 1'b1;
         end
      endcase
   end

   assign scl     = w_scl;
   assign sda     = w_sda;
   assign busy    = r_busy;
   assign done    = r_done;
   assign ack_err = r_ack_err;
   assign data_rd = r_data_rd;

endmodule

// File: tb/tb_i2c_txn_ctrl.sv
// tb/tb_i2c_txn_ctrl.sv - randomized bench: bus decoder, slave model and transaction-level reference
module tb_i2c_txn_ctrl;

   localparam int TOK_S = 'h200;
   localparam int TOK_P = 'h300;
   localparam int CYC_PER_BIT = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       rw;
   logic [6:0] address;
   logic [7:0] register;
   logic [7:0] data_wr;
   logic       sda_in;
   logic       scl;
   logic       sda;
   logic       busy;
   logic       done;
   logic       ack_err;
   logic [7:0] data_rd;
   logic       slave_sda = 1'b1;

   assign sda_in = sda & slave_sda;

   i2c_txn_ctrl #(.CLK_DIV(4)) dut (
      .clk(clk), .rst(rst), .start(start), .rw(rw), .address(address),
      .register(register), .data_wr(data_wr), .sda_in(sda_in), .scl(scl),
      .sda(sda), .busy(busy), .done(done), .ack_err(ack_err), .data_rd(data_rd)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: the transaction as a sequence of bus conditions and 9-bit bytes {ack, data}.
   int         exp_toks[$];
   int         exp_bits;
   int         exp_err;
   int         exp_rd = 0;

   function automatic void push_ev(input int t);
      exp_toks.push_back(t);
      exp_bits += 1;
   endfunction

   function automatic void push_byte(input int b, input bit nak);
      exp_toks.push_back((int'(nak) << 8) | b);
      exp_bits += 9;
   endfunction

   function automatic void build(input bit t_rw, input logic [6:0] a, input logic [7:0] r,
                                 input logic [7:0] d, input logic [7:0] rdv, input int nk);
      exp_toks.delete();
      exp_bits = 0;
      exp_err  = 0;
      push_ev(TOK_S);
      push_byte(int'({a, 1'b0}), nk == 0);
      if (nk == 0) begin exp_err = 1; push_ev(TOK_P); return; end
      push_byte(int'(r), nk == 1);
      if (nk == 1) begin exp_err = 1; push_ev(TOK_P); return; end
      if (!t_rw) begin
         push_byte(int'(d), nk == 2);
         exp_err = (nk == 2) ? 1 : 0;
         push_ev(TOK_P);
         return;
      end
      push_ev(TOK_S);
      push_byte(int'({a, 1'b1}), nk == 2);
      if (nk == 2) begin exp_err = 1; push_ev(TOK_P); return; end
      push_byte(int'(rdv), 1'b1);
      push_ev(TOK_P);
      exp_rd = int'(rdv);
   endfunction

   // Bus decoder and slave; a change of SDA while SCL stays high is a START or STOP token.
   int         toks[$];
   int         clr_req = 0;
   int         clr_seen = 0;
   int         sl_nack = 99;
   logic [7:0] sl_rd = 8'h00;
   int         done_cnt = 0;
   int         wide_cnt = 0;
   logic [8:0] sh = '0;
   int         nbits = 0;
   int         byte_idx = 0;
   int         quiet = 0;
   bit         first_b = 0, pend_rd = 0, reading = 0, byte_end = 0;
   bit         p_scl = 1, p_sda = 1, p_done = 0;

   always @(negedge clk) begin
      bit c_scl, c_sda;
      c_scl = scl;
      c_sda = sda_in;
      if (done) begin
         done_cnt++;
         if (p_done) wide_cnt++;
      end
      p_done = done;
      if (clr_req != clr_seen) begin
         clr_seen = clr_req;
         slave_sda = 1'b1;
         nbits = 0; byte_idx = 0; quiet = 2;
         first_b = 0; pend_rd = 0; reading = 0; byte_end = 0;
         toks.delete();
      end else if (quiet > 0) begin
         quiet--;
      end else if (p_scl && c_scl && p_sda && !c_sda) begin
         toks.push_back(TOK_S);
         nbits = 0;
         first_b = 1;
      end else if (p_scl && c_scl && !p_sda && c_sda) begin
         toks.push_back(TOK_P);
         nbits = 0; byte_idx = 0; reading = 0;
      end else if (!p_scl && c_scl) begin
         sh = {sh[7:0], c_sda};
         nbits++;
         if (nbits == 9) begin
            toks.push_back(int'({sh[0], sh[8:1]}));
            if (first_b && sh[1] && !sh[0]) pend_rd = 1;
            first_b = 0; byte_idx++; nbits = 0; byte_end = 1;
         end
      end else if (p_scl && !c_scl) begin
         if (nbits == 8) begin
            slave_sda = reading || (byte_idx == sl_nack);
         end else if (nbits == 0 && byte_end) begin
            byte_end = 0;
            reading = pend_rd;
            pend_rd = 0;
            slave_sda = reading ? sl_rd[7] : 1'b1;
         end else if (reading && nbits >= 1 && nbits <= 7) begin
            slave_sda = sl_rd[7 - nbits];
         end
      end
      p_scl = c_scl;
      p_sda = c_sda;
   end

   task automatic run_txn(input bit t_rw, input logic [6:0] t_a, input logic [7:0] t_r,
                          input logic [7:0] t_d, input logic [7:0] t_rd, input int t_nk,
                          input int t_mid);
      int cyc;
      int d0;
      bit seen;
      build(t_rw, t_a, t_r, t_d, t_rd, t_nk);
      sl_nack = t_nk;
      sl_rd   = t_rd;
      clr_req++;
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      rw = t_rw; address = t_a; register = t_r; data_wr = t_d;
      @(posedge clk);
      #1 start = 1'b0;
      rw = ~t_rw; address = ~t_a; register = ~t_r; data_wr = ~t_d;
      d0 = done_cnt; cyc = 0; seen = 0;
      while (!seen && cyc < 1000) begin
         @(posedge clk);
         cyc++;
         #1;
         start = (cyc == t_mid);
         if (done) seen = 1;
      end
      start = 1'b0;
      chk("done_latency", cyc, exp_bits * CYC_PER_BIT);
      chk("busy_at_done", busy, 1);
      chk("ack_err", ack_err, exp_err);
      chk("data_rd", data_rd, exp_rd);
      @(posedge clk);
      #1;
      chk("busy_clear", busy, 0);
      chk("done_one_cycle", done, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("done_count", done_cnt - d0, 1);
      chk("tok_count", toks.size(), exp_toks.size());
      for (int i = 0; i < exp_toks.size() && i < toks.size(); i++)
         chk($sformatf("tok%0d", i), toks[i], exp_toks[i]);
   endtask

   task automatic reset_mid_reg();
      sl_nack = 99;
      clr_req++;
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      rw = 1'b0; address = 7'h2B; register = 8'hC3; data_wr = 8'h5A;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (12 * CYC_PER_BIT) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("abort_scl", scl, 1);
      chk("abort_sda", sda, 1);
      chk("abort_busy", busy, 0);
      chk("abort_ack_err", ack_err, 0);
      chk("abort_data_rd", data_rd, 0);
      exp_rd = 0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; rw = 1'b0;
      address = 7'h00; register = 8'h00; data_wr = 8'h00;
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      start = 1'b0;
      chk("rst_scl", scl, 1);
      chk("rst_sda", sda, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ack_err", ack_err, 0);
      chk("rst_data_rd", data_rd, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_start_ignored", busy, 0);
      chk("rst_idle_scl", scl, 1);

      run_txn(1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 99, 0);
      run_txn(1'b1, 7'h50, 8'h12, 8'h00, 8'h3C, 99, 0);
      run_txn(1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 0, 0);
      run_txn(1'b0, 7'h1D, 8'h7E, 8'h81, 8'h00, 99, 100);
      reset_mid_reg();
      run_txn(1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 99, 0);

      for (int i = 0; i < 10; i++) begin
         bit         t_rw;
         logic [6:0] t_a;
         logic [7:0] t_r, t_d, t_rd;
         int         t_nk;
         t_rw = 1'($urandom_range(0, 1));
         t_a  = 7'($urandom);
         t_r  = 8'($urandom);
         t_d  = 8'($urandom);
         t_rd = 8'($urandom);
         case ($urandom_range(0, 5))
            0:       t_nk = 0;
            1:       t_nk = 1;
            2:       t_nk = 2;
            default: t_nk = 99;
         endcase
         run_txn(t_rw, t_a, t_r, t_d, t_rd, t_nk, (i % 3 == 0) ? 50 + i * 20 : 0);
      end

      chk("done_width", wide_cnt, 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/i2c_txn_ctrl.md
I2C_TXN_CTRL -- requirements
Module: i2c_txn_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving the number of clk cycles per quarter SCL bit period; legal values are 1 to 255.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: one-cycle transaction request, sampled only in IDLE.
REQ-005 The block SHALL have port rw, input, 1 bit: 0 = register write, 1 = register read; captured with start.
REQ-006 The block SHALL have port address, input, 7 bits: slave address, captured with start.
REQ-007 The block SHALL have port register, input, 8 bits: register index, captured with start.
REQ-008 The block SHALL have port data_wr, input, 8 bits: write payload, captured with start.
REQ-009 The block SHALL have port sda_in, input, 1 bit: sampled bus SDA level.
REQ-010 The block SHALL have port scl, output, 1 bit: SCL level; 1 = released.
REQ-011 The block SHALL have port sda, output, 1 bit: SDA drive; 1 = released, 0 = pull low.
REQ-012 The block SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a transaction.
REQ-014 The block SHALL have port ack_err, output, 1 bit: valid with done; 1 = slave NACKed.
REQ-015 The block SHALL have port data_rd, output, 8 bits: read byte, valid from done until the next accepted start.

Function
REQ-016 Timing base:
- A prescaler SHALL count CLK_DIV cycles per phase.
- Each bit SHALL have 4 phases: P0 SCL low, SDA updated; P1 SCL low; P2 SCL high; P3 SCL high.
- sda_in SHALL be sampled on the first clk of P3.
REQ-017 The FSM states SHALL be IDLE, START, ADDR, ACK_A, REG, ACK_R, WDATA, ACK_W, RSTART, RADDR, ACK_RA, RDATA, MNACK, STOP.
REQ-018 IDLE SHALL hold scl=1 and sda=1. start=1 in IDLE SHALL capture all inputs and enter START on the next cycle. start while busy SHALL be ignored.
REQ-019 START (one bit period) SHALL drive SDA 1→0 at the P1/P2 boundary while SCL=1, then drive SCL low.
REQ-020 ADDR SHALL shift {address, 1'b0} MSB first. REG SHALL shift register. WDATA SHALL shift data_wr. Each byte SHALL be 8 bit periods.
REQ-021 In ACK_* states the block SHALL release SDA for one bit period. A sampled sda_in=0 means ACK and the FSM proceeds. A sampled 1 means NACK: set ack_err=1 and go to STOP.
REQ-022 Write sequence SHALL be START, ADDR, ACK_A, REG, ACK_R, WDATA, ACK_W, STOP: 29 bit periods in total.
REQ-023 Read sequence SHALL be START, ADDR, ACK_A, REG, ACK_R, RSTART, RADDR ({address,1'b1}), ACK_RA, RDATA, MNACK, STOP: 39 bit periods in total.
- RSTART SHALL first release SDA with SCL low, then raise SCL, then drop SDA while SCL=1.
REQ-024 RDATA SHALL release SDA and shift sda_in into data_rd MSB first, one bit per P3 sample. MNACK SHALL drive SDA=1 (NACK) for one bit period.
REQ-025 STOP SHALL hold SDA=0 with SCL low in P0–P1, raise SCL in P2, and release SDA (0→1) in P3 while SCL=1.
REQ-026 After STOP, done SHALL pulse for exactly one cycle with busy still high. busy SHALL clear on the following cycle and the FSM SHALL return to IDLE.
REQ-027 SDA SHALL change only while SCL=0, except for START, RSTART and STOP edges.
REQ-028 After a NACK, data_rd SHALL retain its previous value.
REQ-029 ack_err SHALL clear on the next accepted start.

Reset
REQ-030 When rst=1 at a clk edge, the block SHALL set state=IDLE, scl=1, sda=1, busy=0, done=0, ack_err=0, data_rd=8'h00, and prescaler/bit counters to 0.
REQ-031 Reset mid-transaction SHALL abort without generating STOP; the bus SHALL be released on the cycle after rst is sampled.
REQ-032 start asserted in the same cycle as rst SHALL be ignored.

Verification (CLK_DIV=4, 16 clk per bit)
REQ-033 Write test: start, rw=0, address=7'h50, register=8'h12, data_wr=8'hA5, slave ACKs → SDA bytes 8'hA0, 8'h12, 8'hA5; done 29×16=464 cycles after start; ack_err=0.
REQ-034 Read test: start, rw=1, address=7'h50, register=8'h12, slave returns 8'h3C → bytes 8'hA0, 8'h12, Sr, 8'hA1; master NACK; data_rd=8'h3C; done after 39×16=624 cycles.
REQ-035 Address NACK test: slave never ACKs → STOP immediately after ACK_A; ack_err=1 with done; busy high for 11 bit periods.
REQ-036 Busy start test: start pulsed mid-write → no effect on bus; done pulses exactly once.
REQ-037 Reset mid-byte test: rst during REG → next cycle scl=1, sda=1, busy=0; a subsequent write completes normally.
REQ-038 Protocol checker test (all tests): no SDA edge while SCL=1 except START, RSTART and STOP; done always one cycle wide.
